// File: rtl/rapid_pkg.sv
// Shared types for the IF/MEM cache arbiter: cache request encodings,
// arbiter state and transaction owner.
package rapid_pkg;

  typedef enum logic {
    CACHE_READ  = 1'b0,
    CACHE_WRITE = 1'b1
  } cache_rw;

  typedef enum logic [1:0] {
    CACHE_NOP    = 2'd0,
    QUARTER_WORD = 2'd1,
    HALF_WORD    = 2'd2,
    WORD         = 2'd3
  } cache_operation;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto a single cache
// port, one transaction outstanding at a time. MEM has priority but may win
// at most MEM_STREAK_MAX times in a row while IF is waiting.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ARB_IDLE  | arbitrate; latch owner and payload on a grant
// ARB_ISSUE | c_req_o held with latched payload until c_ready_i
// ARB_WAIT  | waiting for c_done_i, captures c_rdata_i
// ARB_RESP  | rvalid pulse to owner (delayed one cycle on bypass grants)
module cache_arbiter
  import rapid_pkg::*;
#(
  parameter int MEM_STREAK_MAX = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           if_req_i,
  input  logic [31:0]    if_addr_i,
  output logic           if_gnt_o,
  output logic           if_rvalid_o,
  output logic [31:0]    if_rdata_o,
  input  logic           mem_req_i,
  input  cache_rw        mem_rw_i,
  input  cache_operation mem_op_i,
  input  logic [31:0]    mem_addr_i,
  input  logic [31:0]    mem_wdata_i,
  output logic           mem_gnt_o,
  output logic           mem_rvalid_o,
  output logic           mem_err_o,
  output logic [31:0]    mem_rdata_o,
  output logic           c_req_o,
  output cache_rw        c_rw_o,
  output cache_operation c_op_o,
  output logic [31:0]    c_addr_o,
  output logic [31:0]    c_wdata_o,
  input  logic           c_ready_i,
  input  logic           c_done_i,
  input  logic [31:0]    c_rdata_i
);

  localparam int STREAK_W = $clog2(MEM_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MEM_STREAK_MAX);

  arb_state_t           state_q,  state_d;
  arb_owner_t           owner_q,  owner_d;
  logic                 err_q,    err_d;
  cache_rw              rw_q,     rw_d;
  cache_operation       op_q,     op_d;
  logic [31:0]          addr_q,   addr_d;
  logic [31:0]          wdata_q,  wdata_d;
  logic [31:0]          rdata_q,  rdata_d;
  logic                 if_gnt_q, if_gnt_d;
  logic                 mem_gnt_q, mem_gnt_d;
  logic [STREAK_W-1:0]  streak_q, streak_d;
  logic                 resp_fire;
  logic                 mem_bad;

  function automatic logic is_misaligned(cache_operation op, logic [1:0] addr_lo);
    case (op)
      HALF_WORD: return addr_lo[0];
      WORD:      return addr_lo != 2'b00;
      default:   return 1'b0;
    endcase
  endfunction

  assign mem_bad = is_misaligned(mem_op_i, mem_addr_i[1:0]);

  // A bypass grant (NOP or misaligned) jumps straight to ARB_RESP while its
  // gnt pulse is still pending, so rvalid is held off until the cycle after gnt.
  assign resp_fire = (state_q == ARB_RESP) && !if_gnt_q && !mem_gnt_q;

  // Next-state, arbitration and payload latching
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    err_d     = err_q;
    rw_d      = rw_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    streak_d  = streak_q;
    if_gnt_d  = 1'b0;
    mem_gnt_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!if_req_i) streak_d = '0;
        if (mem_req_i && ((streak_q < STREAK_MAX) || !if_req_i)) begin
          owner_d   = OWN_MEM;
          mem_gnt_d = 1'b1;
          rw_d      = mem_rw_i;
          op_d      = mem_op_i;
          addr_d    = mem_addr_i;
          wdata_d   = mem_wdata_i;
          rdata_d   = '0;
          err_d     = mem_bad;
          if (if_req_i)
            streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 1'b1;
          state_d   = (mem_bad || mem_op_i == CACHE_NOP) ? ARB_RESP : ARB_ISSUE;
        end else if (if_req_i) begin
          owner_d  = OWN_IF;
          if_gnt_d = 1'b1;
          rw_d     = CACHE_READ;
          op_d     = WORD;
          addr_d   = if_addr_i;
          wdata_d  = '0;
          rdata_d  = '0;
          err_d    = 1'b0;
          streak_d = '0;
          state_d  = ARB_ISSUE;
        end
      end
      ARB_ISSUE: if (c_ready_i) state_d = ARB_WAIT;
      ARB_WAIT: begin
        if (c_done_i) begin
          rdata_d = c_rdata_i;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: if (resp_fire) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // State and payload registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_IF;
      err_q     <= 1'b0;
      rw_q      <= CACHE_READ;
      op_q      <= CACHE_NOP;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      streak_q  <= '0;
      if_gnt_q  <= 1'b0;
      mem_gnt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      err_q     <= err_d;
      rw_q      <= rw_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      streak_q  <= streak_d;
      if_gnt_q  <= if_gnt_d;
      mem_gnt_q <= mem_gnt_d;
    end
  end

  assign if_gnt_o     = if_gnt_q;
  assign mem_gnt_o    = mem_gnt_q;
  assign c_req_o      = (state_q == ARB_ISSUE);
  assign c_rw_o       = rw_q;
  assign c_op_o       = op_q;
  assign c_addr_o     = addr_q;
  assign c_wdata_o    = wdata_q;
  assign if_rvalid_o  = resp_fire && (owner_q == OWN_IF);
  assign if_rdata_o   = if_rvalid_o ? rdata_q : '0;
  assign mem_rvalid_o = resp_fire && (owner_q == OWN_MEM);
  assign mem_err_o    = mem_rvalid_o && err_q;
  assign mem_rdata_o  = mem_rvalid_o ? rdata_q : '0;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter: fetch path, MEM-streak fairness,
// bypass grants, stalled store payload and mid-transaction reset.
module tb_cache_arbiter;
  import rapid_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           if_req_i;
  logic [31:0]    if_addr_i;
  logic           if_gnt_o, if_rvalid_o;
  logic [31:0]    if_rdata_o;
  logic           mem_req_i;
  cache_rw        mem_rw_i;
  cache_operation mem_op_i;
  logic [31:0]    mem_addr_i, mem_wdata_i;
  logic           mem_gnt_o, mem_rvalid_o, mem_err_o;
  logic [31:0]    mem_rdata_o;
  logic           c_req_o;
  cache_rw        c_rw_o;
  cache_operation c_op_o;
  logic [31:0]    c_addr_o, c_wdata_o;
  logic           c_ready_i, c_done_i;
  logic [31:0]    c_rdata_i;

  int tests = 0;
  int fails = 0;

  cache_arbiter #(.MEM_STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_rw_i(mem_rw_i), .mem_op_i(mem_op_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_gnt_o(mem_gnt_o), .mem_rvalid_o(mem_rvalid_o), .mem_err_o(mem_err_o),
    .mem_rdata_o(mem_rdata_o),
    .c_req_o(c_req_o), .c_rw_o(c_rw_o), .c_op_o(c_op_o),
    .c_addr_o(c_addr_o), .c_wdata_o(c_wdata_o),
    .c_ready_i(c_ready_i), .c_done_i(c_done_i), .c_rdata_i(c_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_creq"},   32'(c_req_o), 0);
    chk({tag, "_ifrv"},   32'(if_rvalid_o), 0);
    chk({tag, "_memrv"},  32'(mem_rvalid_o), 0);
  endtask

  string seq;
  int    ngnt;

  initial begin
    rst = 1'b1;
    if_req_i = 0; if_addr_i = '0;
    mem_req_i = 0; mem_rw_i = CACHE_READ; mem_op_i = CACHE_NOP;
    mem_addr_i = '0; mem_wdata_i = '0;
    c_ready_i = 0; c_done_i = 0; c_rdata_i = '0;
    step(); step();
    rst = 1'b0;

    // reset state
    chk_quiet("rst");
    chk("rst_ifgnt",  32'(if_gnt_o), 0);
    chk("rst_memgnt", 32'(mem_gnt_o), 0);
    chk("rst_cop",    32'(c_op_o), 32'(CACHE_NOP));
    chk("rst_crw",    32'(c_rw_o), 32'(CACHE_READ));
    chk("rst_caddr",  c_addr_o, 0);
    chk("rst_memerr", 32'(mem_err_o), 0);

    // IF fetch, immediate ready/done: gnt cycle 1, rvalid cycle 3
    if_req_i = 1; if_addr_i = 32'h100;
    c_ready_i = 1; c_done_i = 1; c_rdata_i = 32'h0000_0013;
    chk("if_c0_gnt", 32'(if_gnt_o), 0);
    step();
    chk("if_c1_gnt",  32'(if_gnt_o), 1);
    chk("if_c1_creq", 32'(c_req_o), 1);
    chk("if_c1_op",   32'(c_op_o), 32'(WORD));
    chk("if_c1_rw",   32'(c_rw_o), 32'(CACHE_READ));
    chk("if_c1_addr", c_addr_o, 32'h100);
    if_req_i = 0;
    step();
    chk("if_c2_gnt", 32'(if_gnt_o), 0);
    chk_quiet("if_c2");
    step();
    chk("if_c3_rv",    32'(if_rvalid_o), 1);
    chk("if_c3_rdata", if_rdata_o, 32'h13);
    chk("if_c3_memrv", 32'(mem_rvalid_o), 0);
    step();
    chk("if_c4_rv", 32'(if_rvalid_o), 0);

    // both requesting continuously: M,M,M,M,I,M
    if_req_i = 1; if_addr_i = 32'h200;
    mem_req_i = 1; mem_rw_i = CACHE_READ; mem_op_i = WORD; mem_addr_i = 32'h40;
    seq = ""; ngnt = 0;
    for (int c = 0; c < 60 && ngnt < 6; c++) begin
      step();
      if (mem_gnt_o) begin seq = {seq, "M"}; ngnt++; end
      if (if_gnt_o)  begin seq = {seq, "I"}; ngnt++; end
    end
    if_req_i = 0; mem_req_i = 0;
    chk("fair_count", 32'(ngnt), 6);
    tests++;
    assert (seq == "MMMMIM") else begin
      fails++;
      $error("FAIL fair_order observed=%s expected=MMMMIM", seq);
    end
    for (int c = 0; c < 6; c++) step();
    chk_quiet("fair_drain");

    // misaligned WORD: gnt, then rvalid+err, no cache access
    c_rdata_i = 32'hDEAD_BEEF;
    mem_req_i = 1; mem_op_i = WORD; mem_addr_i = 32'h102;
    step();
    chk("mis_gnt",  32'(mem_gnt_o), 1);
    chk("mis_creq1", 32'(c_req_o), 0);
    chk("mis_rv1",  32'(mem_rvalid_o), 0);
    mem_req_i = 0;
    step();
    chk("mis_rv2",   32'(mem_rvalid_o), 1);
    chk("mis_err",   32'(mem_err_o), 1);
    chk("mis_rdata", mem_rdata_o, 0);
    chk("mis_creq2", 32'(c_req_o), 0);
    step();
    chk_quiet("mis_c3");

    // misaligned HALF_WORD
    mem_req_i = 1; mem_op_i = HALF_WORD; mem_addr_i = 32'h201;
    step(); mem_req_i = 0;
    chk("hmis_creq", 32'(c_req_o), 0);
    step();
    chk("hmis_err", 32'(mem_err_o), 1);
    step();

    // NOP: gnt then rvalid next cycle, err 0, rdata 0
    mem_req_i = 1; mem_op_i = CACHE_NOP; mem_addr_i = 32'h0;
    step();
    chk("nop_gnt",  32'(mem_gnt_o), 1);
    chk("nop_creq", 32'(c_req_o), 0);
    chk("nop_rv1",  32'(mem_rvalid_o), 0);
    mem_req_i = 0;
    step();
    chk("nop_rv2",   32'(mem_rvalid_o), 1);
    chk("nop_err",   32'(mem_err_o), 0);
    chk("nop_rdata", mem_rdata_o, 0);
    step();

    // QUARTER_WORD at odd address is aligned and reaches the cache
    mem_req_i = 1; mem_op_i = QUARTER_WORD; mem_addr_i = 32'h203;
    step(); mem_req_i = 0;
    chk("qw_creq", 32'(c_req_o), 1);
    chk("qw_op",   32'(c_op_o), 32'(QUARTER_WORD));
    step(); step();
    chk("qw_err", 32'(mem_err_o), 0);
    step();

    // stalled store: payload stable, early done ignored
    c_ready_i = 0; c_done_i = 1; c_rdata_i = 32'h1234;
    mem_req_i = 1; mem_rw_i = CACHE_WRITE; mem_op_i = HALF_WORD;
    mem_addr_i = 32'h200; mem_wdata_i = 32'hBEEF;
    step();
    chk("st_gnt", 32'(mem_gnt_o), 1);
    mem_req_i = 0; mem_addr_i = 32'hFFFF_FFF0; mem_wdata_i = 32'h5555_5555;
    mem_op_i = WORD; mem_rw_i = CACHE_READ;
    for (int c = 1; c <= 3; c++) begin
      chk("st_creq",  32'(c_req_o), 1);
      chk("st_rw",    32'(c_rw_o), 32'(CACHE_WRITE));
      chk("st_op",    32'(c_op_o), 32'(HALF_WORD));
      chk("st_addr",  c_addr_o, 32'h200);
      chk("st_wdata", c_wdata_o, 32'hBEEF);
      chk("st_rv",    32'(mem_rvalid_o), 0);
      step();
    end
    c_done_i = 0; c_ready_i = 1;
    chk("st_c4_creq", 32'(c_req_o), 1);
    step();
    chk("st_c5_creq", 32'(c_req_o), 0);
    chk("st_c5_rv",   32'(mem_rvalid_o), 0);
    step();
    c_done_i = 1;
    chk("st_c6_rv", 32'(mem_rvalid_o), 0);
    step();
    chk("st_c7_rv",    32'(mem_rvalid_o), 1);
    chk("st_c7_rdata", mem_rdata_o, 32'h1234);
    chk("st_c7_err",   32'(mem_err_o), 0);
    c_done_i = 0;
    step();

    // reset while in ISSUE: c_req drops next cycle
    c_ready_i = 0;
    if_req_i = 1; if_addr_i = 32'h300;
    step(); if_req_i = 0;
    chk("rsti_creq1", 32'(c_req_o), 1);
    rst = 1;
    step(); rst = 0;
    chk("rsti_creq2", 32'(c_req_o), 0);
    chk("rsti_op",    32'(c_op_o), 32'(CACHE_NOP));

    // reset while in WAIT, then late done
    c_ready_i = 1; c_done_i = 0; c_rdata_i = 32'hAAAA_5555;
    if_req_i = 1; if_addr_i = 32'h400;
    step(); if_req_i = 0;
    step();
    chk("rstw_wait_creq", 32'(c_req_o), 0);
    rst = 1;
    step(); rst = 0;
    c_done_i = 1;
    step();
    chk_quiet("rstw_c1");
    chk("rstw_rdata", if_rdata_o, 0);
    chk("rstw_op",    32'(c_op_o), 32'(CACHE_NOP));
    step();
    chk_quiet("rstw_c2");
    chk("rstw_addr", c_addr_o, 0);
    c_done_i = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter MEM_STREAK_MAX, default 4, max consecutive MEM grants while IF waits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 if_req_i  in  1  IF stage fetch request; held with if_addr_i until if_gnt_o.
REQ-005 if_addr_i  in  32  fetch byte address.
REQ-006 if_gnt_o  out  1  one-cycle pulse: IF request accepted.
REQ-007 if_rvalid_o  out  1  one-cycle pulse: if_rdata_o valid.
REQ-008 if_rdata_o  out  32  fetched instruction word.
REQ-009 mem_req_i  in  1  MEM stage request; held with payload until mem_gnt_o.
REQ-010 mem_rw_i  in  cache_rw  CACHE_READ / CACHE_WRITE.
REQ-011 mem_op_i  in  cache_operation  size: CACHE_NOP, QUARTER_WORD, HALF_WORD, WORD.
REQ-012 mem_addr_i, mem_wdata_i  in  32 each  address, store data.
REQ-013 mem_gnt_o, mem_rvalid_o, mem_err_o  out  1 each  accept pulse, completion pulse, misalignment flag (valid with mem_rvalid_o).
REQ-014 mem_rdata_o  out  32  load data.
REQ-015 c_req_o  out  1  cache request, held until c_ready_i.
REQ-016 c_rw_o, c_op_o, c_addr_o, c_wdata_o  out  cache_rw, cache_operation, 32, 32  cache payload, stable while c_req_o=1.
REQ-017 c_ready_i, c_done_i  in  1 each  cache accept, cache completion; c_rdata_i in 32, valid with c_done_i.

Function
REQ-018 FSM states ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP; one transaction outstanding at a time.
REQ-019 Arbitration only in ARB_IDLE: grant MEM if mem_req_i and (streak<MEM_STREAK_MAX or !if_req_i); else grant IF if if_req_i; else stay.
REQ-020 On grant: latch owner and payload, pulse owner's gnt next cycle, enter ARB_ISSUE.
REQ-021 IF transactions always issue CACHE_READ, WORD.
REQ-022 ARB_ISSUE: c_req_o=1 with latched payload; on c_ready_i go to ARB_WAIT.
REQ-023 ARB_WAIT: on c_done_i capture c_rdata_i, go to ARB_RESP; c_done_i ignored in any other state.
REQ-024 ARB_RESP: one-cycle rvalid pulse to owner with captured data, return to ARB_IDLE (one idle bubble before next arbitration).
REQ-025 Minimum latency, req to rvalid, with c_ready_i and c_done_i each asserted on first eligible cycle: 3 cycles.
REQ-026 mem_op_i=CACHE_NOP: granted, no cache access, ISSUE/WAIT skipped, mem_rvalid_o next cycle after grant, rdata 0, err 0.
REQ-027 Misaligned MEM (HALF_WORD addr[0]=1; WORD addr[1:0]!=0): granted, no cache access, mem_rvalid_o with mem_err_o=1, rdata 0.
REQ-028 Streak counter: +1 on MEM grant while if_req_i=1, saturating at MEM_STREAK_MAX; cleared on IF grant or when if_req_i=0 in ARB_IDLE.
REQ-029 Simultaneous requests, streak<MAX: MEM wins; at streak=MAX: IF wins.
REQ-030 Request dropped before grant is lost without side effect; payload sampled only at grant.

Reset
REQ-031 Reset: state ARB_IDLE, streak 0, all outputs 0 (c_rw_o=CACHE_READ, c_op_o=CACHE_NOP).
REQ-032 Reset mid-transaction: c_req_o drops next cycle, no rvalid issued, late c_done_i ignored.

Structure
REQ-033 arb_state_t (2-bit enum) lives in rapid_pkg; cache_rw and cache_operation reused from it.
REQ-034 Single module; no sub-module; alignment check is an internal function.

Verification
REQ-035 IF only, addr 0x100, ready/done immediate, c_rdata 0x00000013 -> if_gnt cycle 1, c_op WORD/READ, if_rvalid cycle 3 with 0x00000013.
REQ-036 IF and MEM together each cycle, MAX=4 -> grant order M,M,M,M,I,M,...
REQ-037 MEM WORD addr 0x102 -> mem_rvalid with mem_err_o=1, c_req_o never asserted.
REQ-038 MEM write HALF_WORD 0x200 data 0xBEEF, c_ready delayed 3 cycles -> payload stable, mem_rvalid 1 cycle after c_done.
REQ-039 rst during ARB_WAIT, then c_done_i -> no rvalid, state ARB_IDLE, outputs 0.
REQ-040 MEM CACHE_NOP -> mem_gnt then mem_rvalid next cycle, no c_req_o.
